md_scheduler: RTL
=================

// Module: md_scheduler
// PURPOSE
//  Owns HI/LO; sequences mult/multu/div/divu as multi-cycle ops launched from E stage.
//  Raises a D-stage stall for md-class instrs while an op is starting or busy.
//  Feeds HI/LO to the E-stage mfhi/mflo path and commits mthi/mtlo writes.
//  Sits beside the ALU in E; its stall output is ORed into the hazard/stall unit.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   clock; single clock domain
//  reset     in   1   synchronous, active-high reset
//  IR_D      in   32  D-stage instruction
//  IR_E      in   32  E-stage instruction (bubble = 0)
//  rs_E      in   32  forwarded rs operand in E
//  rt_E      in   32  forwarded rt operand in E
//  flush     in   1   E-stage cancel (present only with MDU_FLUSH_EN)
//  start     out  1   combinational: IR_E is mult/multu/div/divu and accepted
//  busy      out  1   registered: op in flight
//  stall_md  out  1   combinational: IR_D md-class && (start || busy)
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  md-class = R-type funct mult,multu,div,divu,mfhi,mflo,mthi,mtlo (op 000000).
//  FSM: IDLE, MULT, DIV. cnt = 4-bit down counter.
//  IDLE: start && mult/multu -> MULT, cnt=MULT_CYCLES-1; div/divu -> DIV, cnt=DIV_CYCLES-1.
//    rs_E/rt_E and op latched at that edge; result computed from latched copies.
//  MULT/DIV: cnt decrements each cycle; at cnt==0 -> IDLE and HI/LO commit same edge.
//  Timing: start in cycle k -> busy=1 cycles k+1..k+N; new HI/LO visible in cycle k+N+1.
//  start = 0 if busy (ignored, not queued); stall_md keeps this unreachable.
//  mthi/mtlo in E, not busy: hi/lo <= rs_E at that edge; while busy: ignored.
//  mult: {hi,lo} = signed 64-bit product; multu: unsigned product.
//  div: lo = quotient truncated toward 0, hi = remainder with dividend's sign.
//  divu: unsigned quotient/remainder.
//  div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Divisor 0 (div/divu): op runs full DIV_CYCLES, busy as normal, hi/lo unchanged.
//  mfhi/mflo consumers read hi/lo directly; the stall makes them see committed values.
//  Reset (any cycle, incl. mid-op): state=IDLE, cnt=0, busy=0, hi=0, lo=0;
//    in-flight result discarded; start/stall_md follow comb. inputs.
// CONFIGURATION
//  MDU_FLUSH_EN defined: flush port exists; flush=1 forces start=0
//    and suppresses mthi/mtlo that cycle. An op already in MULT/DIV is not aborted.
//  MDU_FLUSH_EN undefined: no flush port; every qualifying IR_E op is accepted.
// TESTING
//  T1: rs=7, rt=0xFFFFFFFA, mult; mflo in D -> stall_md 1 for 6 cycles (k..k+5);
//      mflo in E reads lo=0xFFFFFFD6, hi=0xFFFFFFFF.
//  T2: multu 0xFFFFFFFF*0xFFFFFFFF -> busy exactly 5 cycles; hi=0xFFFFFFFE, lo=0x00000001.
//  T3: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles;
//      div 0x80000000/-1 -> lo=0x80000000, hi=0.
//  T4: hi=lo=0x12345678, divu x/0 -> busy 10 cycles, then hi/lo unchanged.
//  T5: mthi rs=0xABCD0000 idle -> hi=0xABCD0000 next cycle;
//      reset asserted at cnt=3 of DIV -> busy=0, hi=lo=0 next cycle, no late commit.
//  T6 (MDU_FLUSH_EN): mult with flush=1 -> start=0, busy stays 0, hi/lo unchanged;
//      flush during busy -> op completes normally.

Source files
------------

// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - HI/LO owner and multi-cycle mult/div sequencer for the E stage
// Optional feature macro: MDU_FLUSH_EN (adds the flush port).
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [1:0]  op_q;          // funct[1:0]: bit1 = divide, bit0 = unsigned
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        r_e;
    logic        mdop_e;
    logic        mthi_e;
    logic        mtlo_e;
    logic        md_class_d;
    logic        cancel;

    assign r_e        = (IR_E[31:26] == 6'b000000);
    assign mdop_e     = r_e && (IR_E[5:2] == 4'b0110);
    assign mthi_e     = r_e && (IR_E[5:0] == 6'h11);
    assign mtlo_e     = r_e && (IR_E[5:0] == 6'h13);
    assign md_class_d = (IR_D[31:26] == 6'b000000) &&
                        ((IR_D[5:2] == 4'b0110) || (IR_D[5:2] == 4'b0100));

`ifdef MDU_FLUSH_EN
    assign cancel = flush;
`else
    assign cancel = 1'b0;
`endif

    assign busy     = (state != ST_IDLE);
    assign start    = mdop_e && !busy && !cancel;
    assign stall_md = md_class_d && (start || busy);

    // One 33-bit signed datapath serves both signednesses: unsigned ops zero-extend,
    // and the extra bit keeps 0x80000000 / -1 from overflowing.
    logic signed [32:0] a_x;
    logic signed [32:0] b_x;
    logic signed [65:0] prod;
    logic signed [32:0] quo;
    logic signed [32:0] rem;

    assign a_x  = {(op_q[0] ? 1'b0 : a_q[31]), a_q};
    assign b_x  = {(op_q[0] ? 1'b0 : b_q[31]), b_q};
    assign prod = a_x * b_x;
    assign quo  = a_x / b_x;
    assign rem  = a_x % b_x;

    logic unused_bits;
    assign unused_bits = ^{IR_D[25:6], IR_E[25:6], IR_E[1:0], prod[65:64], quo[32], rem[32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= IR_E[1:0];
                        a_q  <= rs_E;
                        b_q  <= rt_E;
                        if (IR_E[1]) begin
                            state <= ST_DIV;
                            cnt   <= 4'(DIV_CYCLES - 1);
                        end else begin
                            state <= ST_MULT;
                            cnt   <= 4'(MULT_CYCLES - 1);
                        end
                    end else if (!cancel) begin
                        if (mthi_e) hi <= rs_E;
                        if (mtlo_e) lo <= rs_E;
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        if (state == ST_MULT) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (b_q != 32'd0) begin
                            hi <= rem[31:0];
                            lo <= quo[31:0];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
